fir_decimator: RTL and testbench
================================

Name: fir_decimator

Overview:
- Downstream stage of the 5-tap low-pass FIR filter: consumes the filtered sample stream and keeps every DECIM-th sample, discarding the rest.
- Buffers kept samples in a small FIFO and presents them on a valid/ready output interface, so a slower consumer can drain at its own pace.
- Flags lost samples with a sticky overflow bit.

Parameters:
- signalSize, 8, sample width in bits (signed, two's complement); matches the FIR output width.
- DECIM, 4, decimation factor; integer >= 1; DECIM=1 keeps every sample.
- DEPTH, 8, FIFO depth in samples; power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- x  input  signalSize  signed sample from the FIR filter output.
- x_valid  input  1  x holds a new sample this cycle.
- y  output  signalSize  signed decimated sample at the FIFO head.
- y_valid  output  1  y is valid; high exactly when the FIFO is not empty.
- y_ready  input  1  consumer accepts y this cycle.
- level  output  $clog2(DEPTH)+1  number of samples currently in the FIFO (0..DEPTH).
- overflow  output  1  sticky flag: a kept sample was dropped because the FIFO was full.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset: rst high at a clock edge clears the following.
  - Phase counter cleared to 0.
  - FIFO read and write pointers cleared; level=0; y_valid=0.
  - overflow=0.
  - y value after reset is don't-care while y_valid=0; implement it as 0.
  - rst overrides every other input in that cycle.
  - Reset mid-operation discards all buffered samples; y_valid is 0 from the cycle after the reset edge.
- Phase counter:
  - Range 0..DECIM-1; advances by 1 on every edge with x_valid=1 and wraps DECIM-1 -> 0.
  - Holds when x_valid=0.
  - Advances whether or not the sample is actually stored.
- Keep rule: a sample with x_valid=1 is kept when the phase is 0. The first valid sample after reset is therefore kept, then one sample in every DECIM valid samples.
- Push: a kept sample is written at the FIFO tail on that edge when either:
  - level < DEPTH, or
  - level = DEPTH and a pop occurs in the same cycle (simultaneous push/pop on a full FIFO is legal and level stays DEPTH).
- Drop: a kept sample arriving with level = DEPTH and no pop is discarded. FIFO contents are unchanged and overflow is set to 1 on that edge.
- Pop: occurs on an edge with y_valid=1 and y_ready=1; the head advances.
  - y_ready while y_valid=0 has no effect.
  - A push into an empty FIFO cannot pop in the same cycle.
- Latency: a kept sample pushed at edge N into an empty FIFO appears on y with y_valid=1 from edge N to edge N+1 (one cycle, registered).
- Output stability: y is the registered or RAM head entry. While y_valid=1 and y_ready=0, y and y_valid hold steady.
- Ordering: samples leave in arrival order. Values are passed bit-exact; no arithmetic is applied to sample values.
- level: registered.
  - +1 on push without pop.
  - -1 on pop without push.
  - Unchanged on push with pop, or when neither occurs.
  - Never exceeds DEPTH and never goes below 0.
- Pointers: $clog2(DEPTH) bits each, wrapping naturally at DEPTH.
- overflow:
  - Cleared by ovf_clr=1.
  - If a drop and ovf_clr occur in the same cycle, set wins (overflow=1).
  - Otherwise holds its value.
- Phase counter width: $clog2(DEPTH) is unrelated; size the phase counter as max(1,$clog2(DECIM)) bits.

Test Plan:
- Reset, DECIM=4, y_ready=1, x_valid=1 continuously with x = 1,2,3,...,12 -> y outputs 1,5,9, each with y_valid high for one cycle, one cycle after its push; overflow=0.
- x_valid gapped (high on every 2nd cycle) with x = 10,20,...,80 -> y = 10,50; the phase counter does not advance on idle cycles.
- y_ready=0, DECIM=1, feed 10 samples with x = -1,-2,...,-10 ->
  - level reaches 8 and holds; overflow=1 after the 9th sample.
  - Then y_ready=1 drains -1..-8 in order; level returns to 0 and y_valid drops.
- Full FIFO (level=8) with y_ready=1 and a kept sample in the same cycle -> level stays 8, overflow stays 0, and the new sample appears last in the drain order.
- overflow=1, then ovf_clr=1 in the same cycle as a new drop -> overflow=1. Next cycle ovf_clr=1 with no drop -> overflow=0.
- Reset asserted with level=5 mid-stream -> next cycle level=0, y_valid=0, phase=0. The next valid sample x=0x7F is kept and output as 127.

Source files
------------

// File: rtl/fir_decimator.sv
// fir_decimator: keeps one sample in every DECIM valid FIR output samples and
// buffers the kept samples in a DEPTH-entry FIFO. The FIFO drains through a
// valid/ready output. A sticky overflow bit records kept samples lost to a full FIFO.
module fir_decimator #(
    parameter int signalSize = 8,
    parameter int DECIM      = 4,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [signalSize-1:0] x,
    input  logic                         x_valid,
    output logic signed [signalSize-1:0] y,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [PW-1:0]                phase;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic signed [signalSize-1:0] mem [DEPTH];

    logic full;
    logic keep;
    logic pop;
    logic push;
    logic drop;

    // Handshake decode: which samples are kept, and whether each is stored or lost.
    // NOTE: every signal gets a default before any condition so no latch is inferred.
    always_comb begin
        full = 1'b0;
        keep = 1'b0;
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        full = (level == LEVEL_FULL);
        keep = x_valid && (phase == '0);
        // A pop needs a non-empty FIFO, so a push into an empty FIFO can never pop.
        pop  = y_valid && y_ready;
        // A full FIFO still accepts a kept sample when the head leaves on the same edge.
        push = keep && (!full || pop);
        drop = keep && full && !pop;
    end

    assign y_valid = (level != '0);
    // The head entry is shown only while it is valid; otherwise y reads as 0.
    assign y       = y_valid ? mem[rd_ptr] : '0;

    // Phase counter: counts valid input samples modulo DECIM, whether or not they are stored.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (x_valid) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sample storage. It is written at the tail on a push.
    // NOTE: the storage array has no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= x;
        end
    end

    // Sticky overflow: a drop sets it, and the set wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator. It drives two instances: one with DECIM=4 and one with DECIM=1.
// A behavioural scoreboard per instance tracks the expected FIFO contents, level and overflow.
// The scenario tasks add direct checks of the output sequences they expect.
module tb_fir_decimator;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic signed [W-1:0] a_x, a_y;
    logic                a_xv, a_rdy, a_clr, a_yv, a_ovf;
    logic [LW-1:0]       a_level;

    logic signed [W-1:0] b_x, b_y;
    logic                b_xv, b_rdy, b_clr, b_yv, b_ovf;
    logic [LW-1:0]       b_level;

    fir_decimator #(.signalSize(W), .DECIM(4), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .x(a_x), .x_valid(a_xv), .y(a_y), .y_valid(a_yv),
        .y_ready(a_rdy), .level(a_level), .overflow(a_ovf), .ovf_clr(a_clr)
    );

    fir_decimator #(.signalSize(W), .DECIM(1), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .x(b_x), .x_valid(b_xv), .y(b_y), .y_valid(b_yv),
        .y_ready(b_rdy), .level(b_level), .overflow(b_ovf), .ovf_clr(b_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // Scoreboard state: expected FIFO contents, phase and overflow for each instance.
    logic signed [W-1:0] qa[$];
    logic signed [W-1:0] qb[$];
    int pha = 0;
    bit ova = 1'b0;
    bit ovb = 1'b0;

    task automatic model_a();
        bit pop, keep, drop;
        if (rst) begin
            qa.delete(); pha = 0; ova = 1'b0;
            return;
        end
        pop  = (qa.size() > 0) && a_rdy;
        keep = a_xv && (pha == 0);
        drop = 1'b0;
        if (pop) void'(qa.pop_front());
        if (keep) begin
            if (qa.size() < DEPTH) qa.push_back(a_x);
            else drop = 1'b1;
        end
        if (drop) ova = 1'b1;
        else if (a_clr) ova = 1'b0;
        if (a_xv) pha = (pha == 3) ? 0 : pha + 1;
    endtask

    task automatic model_b();
        bit pop, drop;
        if (rst) begin
            qb.delete(); ovb = 1'b0;
            return;
        end
        pop  = (qb.size() > 0) && b_rdy;
        drop = 1'b0;
        if (pop) void'(qb.pop_front());
        if (b_xv) begin
            if (qb.size() < DEPTH) qb.push_back(b_x);
            else drop = 1'b1;
        end
        if (drop) ovb = 1'b1;
        else if (b_clr) ovb = 1'b0;
    endtask

    always @(posedge clk) begin
        model_a();
        model_b();
    end

    // Scoreboard compare: on every falling edge the DUT state must match the model.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (a_yv !== (qa.size() != 0)) begin
                n_bad++; $display("FAIL sb_a_valid: got %b expected %b", a_yv, qa.size() != 0);
            end
            n_cmp++;
            if (a_level !== LW'(qa.size())) begin
                n_bad++; $display("FAIL sb_a_level: got %0d expected %0d", a_level, qa.size());
            end
            n_cmp++;
            if (a_ovf !== ova) begin
                n_bad++; $display("FAIL sb_a_overflow: got %b expected %b", a_ovf, ova);
            end
            if (qa.size() != 0) begin
                n_cmp++;
                if (a_y !== qa[0]) begin
                    n_bad++; $display("FAIL sb_a_y: got %0d expected %0d", a_y, qa[0]);
                end
            end
            n_cmp++;
            if (b_yv !== (qb.size() != 0)) begin
                n_bad++; $display("FAIL sb_b_valid: got %b expected %b", b_yv, qb.size() != 0);
            end
            n_cmp++;
            if (b_level !== LW'(qb.size())) begin
                n_bad++; $display("FAIL sb_b_level: got %0d expected %0d", b_level, qb.size());
            end
            n_cmp++;
            if (b_ovf !== ovb) begin
                n_bad++; $display("FAIL sb_b_overflow: got %b expected %b", b_ovf, ovb);
            end
            if (qb.size() != 0) begin
                n_cmp++;
                if (b_y !== qb[0]) begin
                    n_bad++; $display("FAIL sb_b_y: got %0d expected %0d", b_y, qb[0]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (a_yv !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid: got %b expected 0", a_yv); end
        n_cmp++; if (a_level !== '0) begin n_bad++; $display("FAIL reset_a_level: got %0d expected 0", a_level); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_a_overflow: got %b expected 0", a_ovf); end
        n_cmp++; if (a_y !== '0) begin n_bad++; $display("FAIL reset_a_y: got %0d expected 0", a_y); end
        n_cmp++; if (b_yv !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid: got %b expected 0", b_yv); end
        n_cmp++; if (b_level !== '0) begin n_bad++; $display("FAIL reset_b_level: got %0d expected 0", b_level); end
        n_cmp++; if (b_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_b_overflow: got %b expected 0", b_ovf); end
        n_cmp++; if (b_y !== '0) begin n_bad++; $display("FAIL reset_b_y: got %0d expected 0", b_y); end
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_decimate();
        logic signed [W-1:0] got[$];
        logic signed [W-1:0] exp_v [3] = '{8'sd1, 8'sd5, 8'sd9};
        a_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_xv = (i <= 12);
            a_x  = (i <= 12) ? W'(i) : '0;
            tick();
            if (a_yv) got.push_back(a_y);
        end
        a_xv = 1'b0;
        n_cmp++;
        if (got.size() != 3) begin n_bad++; $display("FAIL decimate_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL decimate_y[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 'x, exp_v[i]);
            end
        end
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL decimate_overflow: got %b expected 0", a_ovf); end
    endtask

    task automatic test_gapped();
        logic signed [W-1:0] got[$];
        logic signed [W-1:0] exp_v [2] = '{8'sd10, 8'sd50};
        a_rdy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            a_xv = (i % 2 == 0) && (i < 16);
            a_x  = a_xv ? W'(10 * (i / 2 + 1)) : '0;
            tick();
            if (a_yv) got.push_back(a_y);
        end
        a_xv = 1'b0;
        n_cmp++;
        if (got.size() != 2) begin n_bad++; $display("FAIL gapped_count: got %0d expected 2", got.size()); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL gapped_y[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 'x, exp_v[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [W-1:0] got[$];
        b_rdy = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            b_xv = 1'b1;
            b_x  = W'(-i);
            tick();
            if (i == 8) begin
                n_cmp++; if (b_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level8: got %0d expected 8", b_level); end
                n_cmp++; if (b_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_before_drop: got %b expected 0", b_ovf); end
            end
            if (i == 9) begin
                n_cmp++; if (b_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_after_9th: got %b expected 1", b_ovf); end
            end
        end
        b_xv = 1'b0;
        n_cmp++; if (b_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level_hold: got %0d expected 8", b_level); end
        b_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (b_yv) got.push_back(b_y);
            tick();
        end
        n_cmp++;
        if (got.size() != 8) begin n_bad++; $display("FAIL drain_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== W'(-(i + 1))) begin
                n_bad++; $display("FAIL drain_y[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 'x, -(i + 1));
            end
        end
        n_cmp++; if (b_level !== '0) begin n_bad++; $display("FAIL drain_level: got %0d expected 0", b_level); end
        n_cmp++; if (b_yv !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %b expected 0", b_yv); end
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic signed [W-1:0] got[$];
        b_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            b_xv = 1'b1; b_x = W'(i);
            tick();
        end
        b_x = 8'sd99; b_rdy = 1'b1;
        tick();
        b_xv = 1'b0;
        n_cmp++; if (b_level !== 4'd8) begin n_bad++; $display("FAIL full_pp_level: got %0d expected 8", b_level); end
        n_cmp++; if (b_ovf !== 1'b0) begin n_bad++; $display("FAIL full_pp_overflow: got %b expected 0", b_ovf); end
        for (int i = 0; i < 10; i++) begin
            if (b_yv) got.push_back(b_y);
            tick();
        end
        n_cmp++;
        if (got.size() != 8) begin n_bad++; $display("FAIL full_pp_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            logic signed [W-1:0] e;
            e = (i < 7) ? W'(i + 2) : 8'sd99;
            n_cmp++;
            if (i >= got.size() || got[i] !== e) begin
                n_bad++; $display("FAIL full_pp_y[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 'x, e);
            end
        end
    endtask

    task automatic test_ovf_clear();
        b_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b_xv = 1'b1; b_x = W'(100 + i);
            tick();
        end
        n_cmp++; if (b_ovf !== 1'b1) begin n_bad++; $display("FAIL clr_drop_sets: got %b expected 1", b_ovf); end
        b_x = 8'sd109; b_clr = 1'b1;
        tick();
        n_cmp++; if (b_ovf !== 1'b1) begin n_bad++; $display("FAIL clr_set_wins: got %b expected 1", b_ovf); end
        b_xv = 1'b0;
        tick();
        n_cmp++; if (b_ovf !== 1'b0) begin n_bad++; $display("FAIL clr_clears: got %b expected 0", b_ovf); end
        b_clr = 1'b0; b_rdy = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (b_level !== '0) begin n_bad++; $display("FAIL clr_drain_level: got %0d expected 0", b_level); end
    endtask

    task automatic test_mid_reset();
        a_rdy = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            a_xv = 1'b1; a_x = W'(i);
            tick();
        end
        a_xv = 1'b0;
        n_cmp++; if (a_level !== 4'd5) begin n_bad++; $display("FAIL midrst_level5: got %0d expected 5", a_level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (a_level !== '0) begin n_bad++; $display("FAIL midrst_level: got %0d expected 0", a_level); end
        n_cmp++; if (a_yv !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", a_yv); end
        a_xv = 1'b1; a_x = 8'sh7F;
        tick();
        a_xv = 1'b0;
        n_cmp++; if (a_yv !== 1'b1) begin n_bad++; $display("FAIL midrst_kept_valid: got %b expected 1", a_yv); end
        n_cmp++; if (a_y !== 8'sd127) begin n_bad++; $display("FAIL midrst_kept_y: got %0d expected 127", a_y); end
        a_rdy = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        a_x = '0; a_xv = 1'b0; a_rdy = 1'b0; a_clr = 1'b0;
        b_x = '0; b_xv = 1'b0; b_rdy = 1'b0; b_clr = 1'b0;
        tick();
        test_reset();
        test_decimate();
        test_gapped();
        test_overflow();
        test_full_push_pop();
        test_ovf_clear();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
